// File: rtl/tstamp_ser_tx.sv
// Timestamp FIFO serial transmitter: pops 16-bit words and sends them MSB-first.
// Define TSTAMP_TX_PARITY_EN to append an even-parity bit to every frame.
module tstamp_ser_tx #(
    parameter int WORDWIDTH = 16,
    parameter int CNTWIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 en_i,
    input  logic                 empty_i,
    input  logic [WORDWIDTH-1:0] data_i,
    output logic                 re_o,
    output logic                 ser_o,
    output logic                 frame_o,
    output logic                 busy_o,
    output logic [CNTWIDTH-1:0]  word_cnt_o
);

    localparam int BCW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef TSTAMP_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WORDWIDTH-1:0] shreg_q;
    logic [BCW-1:0]       bitcnt_q;
    logic [CNTWIDTH-1:0]  cnt_q;
    logic                 go;

`ifdef TSTAMP_TX_PARITY_EN
    logic                 par_q;
`endif

    // A word is only requested when the FIFO was seen non-empty.
    assign go = en_i && !empty_i;

    always_comb begin
        state_d = state_q;
        re_o    = 1'b0;
        ser_o   = 1'b0;
        frame_o = 1'b0;
        busy_o  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (go) state_d = S_POP;
            end
            S_POP: begin
                re_o    = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_START;
            end
            S_START: begin
                ser_o   = 1'b1;
                frame_o = 1'b1;
                state_d = S_DATA;
            end
            S_DATA: begin
                ser_o   = shreg_q[WORDWIDTH-1];
                frame_o = 1'b1;
                if (bitcnt_q == '0) begin
`ifdef TSTAMP_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef TSTAMP_TX_PARITY_EN
            S_PARITY: begin
                ser_o   = par_q;
                frame_o = 1'b1;
                state_d = S_STOP;
            end
`endif
            S_STOP: begin
                state_d = go ? S_POP : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
`ifdef TSTAMP_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_LOAD: begin
                    shreg_q <= data_i;
`ifdef TSTAMP_TX_PARITY_EN
                    par_q   <= ^data_i;
`endif
                end
                S_START: begin
                    bitcnt_q <= BCW'(WORDWIDTH - 1);
                end
                S_DATA: begin
                    shreg_q <= {shreg_q[WORDWIDTH-2:0], 1'b0};
                    if (bitcnt_q != '0) bitcnt_q <= bitcnt_q - 1'b1;
                end
                S_STOP: begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign word_cnt_o = cnt_q;

endmodule
